// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes, FSM encoding
// and lane geometry of the 32-bit little-endian data word.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam int LANE_BITS  = 8;
  localparam int LANE_IDX_W = 2;
  localparam int HALF_BITS  = 16;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bus of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// resp_valid is a single-cycle pulse with no backpressure.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word
// store data into the word previously read from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0]           word,
  input  logic [LANE_IDX_W-1:0] addr_lo,
  input  logic [2:0]            funct3,
  input  logic [31:0]           wdata,
  output logic [31:0]           load_val,
  output logic [31:0]           store_word
);

  logic [LANE_BITS-1:0] lane_b;
  logic [HALF_BITS-1:0] lane_h;

  always_comb begin
    lane_b = word[LANE_BITS*addr_lo +: LANE_BITS];
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_val = {24'h0, lane_b};
      F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_val = {16'h0, lane_h};
      default: load_val = word;
    endcase

    // Untouched lanes keep the old word; a full-word store ignores it.
    store_word = word;
    case (funct3)
      F3_B: store_word[LANE_BITS*addr_lo +: LANE_BITS] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a word-addressed data memory:
// IDLE -> (RD) -> (WR) -> RESP, with read-modify-write for byte/half stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output lsu_state_e  dbg_state
);

  lsu_state_e            state, state_next;
  logic                  accept;
  logic                  fault_in;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [LANE_IDX_W-1:0] addr_lo_q;
  logic [31:0]           wdata_q;
  logic [31:0]           load_val;
  logic [31:0]           store_word;

  function automatic logic req_fault(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic f;
    case (f3)
      F3_B, F3_BU: f = 1'b0;
      F3_H, F3_HU: f = a[0];
      F3_W:        f = (a[1:0] != 2'b00);
      default:     f = 1'b1;
    endcase
    if (wr && f3[2]) f = 1'b1;
    if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS)) f = 1'b1;
    return f;
  endfunction

  assign accept   = bus.req_valid && (state == ST_IDLE);
  assign fault_in = req_fault(bus.req_write, bus.req_funct3, bus.req_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (fault_in)                                       state_next = ST_RESP;
          else if (bus.req_write && bus.req_funct3 == F3_W)   state_next = ST_WR;
          else                                                state_next = ST_RD;
        end
      end
      ST_RD:   state_next = write_q ? ST_WR : ST_RESP;
      ST_WR:   state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Decoded from state so a reset drops mem_write without waiting for a clock.
  always_comb begin
    mem_write     = (state == ST_WR);
    bus.req_ready = (state == ST_IDLE);
    dbg_state     = state;
  end

  lsu_align u_align (
    .word       (mem_read_data),
    .addr_lo    (addr_lo_q),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // mem_write_data doubles as the merge register for byte/half stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q         <= 1'b0;
      funct3_q        <= 3'b000;
      addr_lo_q       <= '0;
      wdata_q         <= '0;
      mem_address     <= '0;
      mem_write_data  <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
    end else begin
      bus.resp_valid <= (state_next == ST_RESP);
      bus.resp_err   <= accept && fault_in;
      bus.resp_rdata <= (state == ST_RD && !write_q) ? load_val : 32'h0;
      if (accept) begin
        write_q        <= bus.req_write;
        funct3_q       <= bus.req_funct3;
        addr_lo_q      <= bus.req_addr[1:0];
        wdata_q        <= bus.req_wdata;
        mem_address    <= {bus.req_addr[31:2], 2'b00};
        mem_write_data <= bus.req_wdata;
      end
      if (state == ST_RD && write_q) mem_write_data <= store_word;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 256-word data memory preloaded mem[0]=5, mem[1]=10, mem[2]=15.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  lsu_state_e  dbg_state;
  logic        mem_load;
  logic [31:0] mem [0:255];

  int n_checks;
  int n_errors;

  lsu_if bus ();

  load_store_unit #(.DEPTH_WORDS(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0] <= 32'd5;
      mem[1] <= 32'd10;
      mem[2] <= 32'd15;
    end else if (mem_write) begin
      mem[mem_address[9:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_address[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: one request, returns result, accept-to-response latency and write cycles
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output logic err, output int lat, output int n_wr);
    int guard;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat  = 1;
    n_wr = 0;
    while (!bus.resp_valid && lat < 10) begin
      if (mem_write) n_wr++;
      @(negedge clk);
      lat++;
    end
    check("resp_seen", 32'(bus.resp_valid), 32'd1);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] rd;
    logic        er;
    int          lat, nw;
    do_req(v.wr, v.f3, v.addr, v.wd, rd, er, lat, nw);
    check({tag, "_rdata"}, rd, v.exp_rdata);
    check({tag, "_err"}, 32'(er), 32'(v.exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_nwr"}, 32'(nw), 32'(v.exp_wr));
  endtask

  initial begin
    logic [31:0] rd;
    vec_t v;
    int   lat;
    int   guard;
    n_checks = 0;
    n_errors = 0;

    // reset block
    rst_n          = 1'b0;
    mem_load       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    #2;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err",   32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_addr",   mem_address, 32'h0);
    check("rst_mem_wdata",  mem_write_data, 32'h0);
    check("rst_mem_write",  32'(mem_write), 32'd0);
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_state",      32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    rst_n    = 1'b1;

    // 1: word load
    v = '{1'b0, F3_W, 32'h4, 32'h0, 32'h0000000A, 1'b0, 2, 0};
    run_vec("t1_lw", v);

    // 5: back-to-back with req_valid held high
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 32'h8;
    check("t5_busy_rd", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("t5_first_valid", 32'(bus.resp_valid), 32'd1);
    check("t5_first_rdata", bus.resp_rdata, 32'd5);
    check("t5_busy_resp", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("t5_ready_idle", 32'(bus.req_ready), 32'd1);
    check("t5_no_resp_idle", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t5_second_lat", 32'(lat), 32'd2);
    check("t5_second_rdata", bus.resp_rdata, 32'd15);

    // 2: SW then sub-word loads
    v = '{1'b1, F3_W,  32'h8, 32'h80FF7F01, 32'h0, 1'b0, 2, 1}; run_vec("t2_sw", v);
    v = '{1'b0, F3_B,  32'h8, 32'h0, 32'h00000001, 1'b0, 2, 0}; run_vec("t2_lb", v);
    v = '{1'b0, F3_BU, 32'h9, 32'h0, 32'h0000007F, 1'b0, 2, 0}; run_vec("t2_lbu", v);
    v = '{1'b0, F3_H,  32'hA, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0}; run_vec("t2_lh", v);
    v = '{1'b0, F3_HU, 32'hA, 32'h0, 32'h000080FF, 1'b0, 2, 0}; run_vec("t2_lhu", v);
    v = '{1'b0, F3_B,  32'hB, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0}; run_vec("t2_lb3", v);

    // 3: byte store read-modify-write, half store into upper half
    v = '{1'b1, F3_B, 32'h1, 32'h000000AB, 32'h0, 1'b0, 3, 1}; run_vec("t3_sb", v);
    v = '{1'b0, F3_W, 32'h0, 32'h0, 32'h0000AB05, 1'b0, 2, 0}; run_vec("t3_lw", v);
    v = '{1'b1, F3_H, 32'h6, 32'h1234BEEF, 32'h0, 1'b0, 3, 1}; run_vec("t3_sh", v);
    v = '{1'b0, F3_W, 32'h4, 32'h0, 32'hBEEF000A, 1'b0, 2, 0}; run_vec("t3_lw2", v);

    // 4: faults
    v = '{1'b0, F3_W,   32'h2,   32'h0,  32'h0, 1'b1, 1, 0}; run_vec("t4_lw_mis", v);
    v = '{1'b1, F3_H,   32'h3,   32'hFF, 32'h0, 1'b1, 1, 0}; run_vec("t4_sh_mis", v);
    v = '{1'b0, 3'b011, 32'h0,   32'h0,  32'h0, 1'b1, 1, 0}; run_vec("t4_ill", v);
    v = '{1'b1, F3_B,   32'h400, 32'hFF, 32'h0, 1'b1, 1, 0}; run_vec("t4_oor", v);
    v = '{1'b1, F3_BU,  32'h0,   32'hFF, 32'h0, 1'b1, 1, 0}; run_vec("t4_sbu", v);
    v = '{1'b0, F3_W,   32'h3FC, 32'h0,  32'h0, 1'b0, 2, 0}; run_vec("t4_last", v);
    check("t4_mem0", mem[0], 32'h0000AB05);
    check("t4_mem255", mem[255], 32'h0);

    // 6: reset during WR of SW
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h4;
    bus.req_wdata  = 32'h0000DEAD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t6_in_wr", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_write_drop", 32'(mem_write), 32'd0);
    check("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid) guard++;
      @(negedge clk);
    end
    check("t6_no_resp", 32'(guard), 32'd0);
    check("t6_ready", 32'(bus.req_ready), 32'd1);
    v = '{1'b0, F3_W, 32'h4, 32'h0, 32'hBEEF000A, 1'b0, 2, 0}; run_vec("t6_lw", v);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
